// File: rtl/ifu_imem_resp.sv
// ifu_imem_resp
//
// Instruction-memory responder for the IFU fetch REQ/RSP channel.
//
// It accepts one fetch request at a time and reads a 32-bit word from an
// internal RAM. It presents the word on the RSP channel LATENCY cycles after
// the request handshake, and holds it there until the IFU accepts it. A
// separate preload port lets loaders and benches fill the RAM. The RAM is
// not cleared by reset.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-low
//   ifu_req_valid  fetch request valid
//   ifu_req_ready  responder can accept a request
//   ifu_req_pc     fetch byte address
//   ifu_rsp_valid  instruction valid
//   ifu_rsp_ready  IFU accepts the instruction
//   ifu_rsp_instr  returned instruction (FILL_INSTR on a faulting access)
//   ifu_rsp_err    fault flag, present only when IFU_IMEM_ERR_EN is defined
//   mem_wr_en      preload write strobe
//   mem_wr_addr    preload byte address (misaligned/out-of-range dropped)
//   mem_wr_data    preload data
//
// Optional feature macro: IFU_IMEM_ERR_EN adds the ifu_rsp_err output.

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module ifu_imem_resp #(
   parameter int unsigned            MEM_DEPTH  = 1024,
   parameter logic [`PC_SIZE-1:0]    BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned            LATENCY    = 1,
   parameter logic [`INSTR_SIZE-1:0] FILL_INSTR = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ifu_req_valid,
   output logic                    ifu_req_ready,
   input  logic [`PC_SIZE-1:0]     ifu_req_pc,
   output logic                    ifu_rsp_valid,
   input  logic                    ifu_rsp_ready,
   output logic [`INSTR_SIZE-1:0]  ifu_rsp_instr,
`ifdef IFU_IMEM_ERR_EN
   output logic                    ifu_rsp_err,
`endif
   input  logic                    mem_wr_en,
   input  logic [`PC_SIZE-1:0]     mem_wr_addr,
   input  logic [`INSTR_SIZE-1:0]  mem_wr_data
);

   localparam int PC_W  = `PC_SIZE;
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   // SPAN is the RAM size in bytes. It is one bit wider than the pc, so the
   // range check never wraps.
   localparam logic [PC_W:0] SPAN   = (PC_W+1)'(MEM_DEPTH) << 2;
   localparam logic [3:0]    LAT_M1 = 4'(LATENCY - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]             state, state_nx;
   logic [3:0]             count, count_nx;
   logic [PC_W-1:0]        pc_q;
   logic [PC_W-1:0]        rd_pc;
   logic                   enter_resp;
   logic                   rd_fault;
   logic                   req_hs, rsp_hs;
   logic [`INSTR_SIZE-1:0] mem [MEM_DEPTH];

   // The check is done in PC_W+1 bits. A pc below BASE_ADDR therefore
   // produces a huge offset and is never aliased back into the RAM.
   function automatic logic addr_fault(input logic [PC_W-1:0] pc);
      logic [PC_W:0] off_wide;
      off_wide = {1'b0, pc} - {1'b0, BASE_ADDR};
      return (pc[1:0] != 2'b00) || (pc < BASE_ADDR) || (off_wide >= SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [PC_W-1:0] pc);
      logic [PC_W-1:0] off;
      off = pc - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   assign ifu_rsp_valid = (state == S_RESP);
   assign ifu_req_ready = (state == S_IDLE) || ((state == S_RESP) && ifu_rsp_ready);
   assign req_hs        = ifu_req_valid && ifu_req_ready;
   assign rsp_hs        = ifu_rsp_valid && ifu_rsp_ready;
   assign rd_fault      = addr_fault(rd_pc);

   // Next-state logic. A request arriving in RESP can only handshake in the
   // same cycle as the response, so IDLE and RESP share the request branch.
   // The word is read on the edge that enters RESP. With LATENCY 1, that edge
   // is the request edge itself, so the live pc is used as the read address.
   always_comb begin
      state_nx   = state;
      count_nx   = count;
      enter_resp = 1'b0;
      rd_pc      = pc_q;
      case (state)
         S_IDLE, S_RESP: begin
            if (req_hs) begin
               count_nx = LAT_M1;
               if (LATENCY == 1) begin
                  state_nx   = S_RESP;
                  enter_resp = 1'b1;
                  rd_pc      = ifu_req_pc;
               end else begin
                  state_nx = S_WAIT;
               end
            end else if (rsp_hs) begin
               state_nx = S_IDLE;
            end
         end
         S_WAIT: begin
            if (count <= 4'd1) begin
               state_nx   = S_RESP;
               enter_resp = 1'b1;
               count_nx   = '0;
            end else begin
               count_nx = count - 4'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM registers and response capture. The RAM read sees contents from
   // before this edge, so a preload write on the same edge is not returned.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         count         <= '0;
         pc_q          <= '0;
         ifu_rsp_instr <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (req_hs) begin
            pc_q <= ifu_req_pc;
         end
         if (enter_resp) begin
            ifu_rsp_instr <= rd_fault ? FILL_INSTR : mem[addr_idx(rd_pc)];
         end
      end
   end

   // Preload port. Writes are accepted in any FSM state. They are dropped
   // while reset is asserted, and also when the address is not a valid
   // aligned word inside the RAM.
   always_ff @(posedge clk) begin
      if (rst && mem_wr_en && !addr_fault(mem_wr_addr)) begin
         mem[addr_idx(mem_wr_addr)] <= mem_wr_data;
      end
   end

`ifdef IFU_IMEM_ERR_EN
   logic rsp_fault;

   // The fault flag is latched alongside the word. It is only shown while
   // the response is valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_fault <= 1'b0;
      end else if (enter_resp) begin
         rsp_fault <= rd_fault;
      end
   end

   assign ifu_rsp_err = ifu_rsp_valid && rsp_fault;
`endif

endmodule

// File: tb/tb_ifu_imem_resp.sv
// tb_ifu_imem_resp
//
// Bench for ifu_imem_resp with two instances: LATENCY=1 (index 0) and
// LATENCY=3 (index 1). Both share clock, reset and the preload port.
//
// A transaction-level model tracks the outstanding request per instance:
//   - when its response becomes due, as an absolute cycle number;
//   - the word it will return.
// The model keeps its own copy of the RAM. On every negedge the bench checks
// DUT valid/ready/instr against the model. Directed literals pin the
// model's view of the expected behaviour.

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module tb_ifu_imem_resp;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] FILL  = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
   logic [1:0][31:0] req_pc, rsp_instr;
   logic             wr_en;
   logic [31:0]      wr_addr, wr_data;
`ifdef IFU_IMEM_ERR_EN
   logic [1:0]       rsp_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 0;

   // Model state
   logic [31:0] mmem [2][DEPTH];
   bit          m_out [2];
   int          m_due [2];
   logic [31:0] m_pc [2];
   logic [31:0] m_instr [2];
   bit          m_err [2];

   always #5 clk = ~clk;

   ifu_imem_resp #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .FILL_INSTR(FILL)) dut_l1 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(req_valid[0]), .ifu_req_ready(req_ready[0]), .ifu_req_pc(req_pc[0]),
      .ifu_rsp_valid(rsp_valid[0]), .ifu_rsp_ready(rsp_ready[0]), .ifu_rsp_instr(rsp_instr[0]),
`ifdef IFU_IMEM_ERR_EN
      .ifu_rsp_err(rsp_err[0]),
`endif
      .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data)
   );

   ifu_imem_resp #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3), .FILL_INSTR(FILL)) dut_l3 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(req_valid[1]), .ifu_req_ready(req_ready[1]), .ifu_req_pc(req_pc[1]),
      .ifu_rsp_valid(rsp_valid[1]), .ifu_rsp_ready(rsp_ready[1]), .ifu_rsp_instr(rsp_instr[1]),
`ifdef IFU_IMEM_ERR_EN
      .ifu_rsp_err(rsp_err[1]),
`endif
      .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data)
   );

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit in_ram(input logic [31:0] a);
      longint unsigned p, b;
      p = 64'(a);
      b = 64'(BASE);
      return (a[1:0] == 2'b00) && (p >= b) && (p < b + 4 * DEPTH);
   endfunction

   function automatic logic [32:0] model_read(input int i, input logic [31:0] a);
      if (!in_ram(a)) return {1'b1, FILL};
      return {1'b0, mmem[i][int'((a - BASE) >> 2)]};
   endfunction

   function automatic bit exp_valid(input int i);
      return m_out[i] && (cyc >= m_due[i]);
   endfunction

   function automatic bit exp_ready(input int i);
      return !m_out[i] || (exp_valid(i) && rsp_ready[i]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
   endtask

   // Model update at each rising edge, using the inputs of the cycle that
   // just ended. A response handshake clears the slot; a request handshake
   // fills it. The word is captured one cycle before it is due, and before
   // this edge's preload write is applied.
   always @(posedge clk) begin
      bit v, rh, qh;
      if (!rst) begin
         m_out[0] = 0;
         m_out[1] = 0;
         chk_en   = 1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            v  = exp_valid(i);
            rh = v && rsp_ready[i];
            qh = req_valid[i] && exp_ready(i);
            if (rh) m_out[i] = 0;
            if (qh) begin
               m_out[i] = 1;
               m_due[i] = cyc + lat(i);
               m_pc[i]  = req_pc[i];
            end
            if (m_out[i] && m_due[i] == cyc + 1) {m_err[i], m_instr[i]} = model_read(i, m_pc[i]);
         end
         if (wr_en && in_ram(wr_addr)) begin
            mmem[0][int'((wr_addr - BASE) >> 2)] = wr_data;
            mmem[1][int'((wr_addr - BASE) >> 2)] = wr_data;
         end
      end
      cyc++;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(exp_valid(i)));
            check($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(exp_ready(i)));
            if (exp_valid(i)) check($sformatf("rsp_instr[%0d]", i), rsp_instr[i], m_instr[i]);
`ifdef IFU_IMEM_ERR_EN
            check($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), 32'(exp_valid(i) && m_err[i]));
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      step();
      wr_en = 0;
   endtask

   // Holds a request until it handshakes. Returns one cycle after the
   // handshake edge.
   task automatic send_req(input int i, input logic [31:0] pc);
      bit done;
      done = 0;
      req_valid[i] = 1;
      req_pc[i]    = pc;
      for (int k = 0; k < 40 && !done; k++) begin
         #1;
         done = req_ready[i];
         step();
      end
      req_valid[i] = 0;
      if (!done) timeout($sformatf("req_hs[%0d]", i));
   endtask

   task automatic wait_valid(input int i);
      bit seen;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         #1;
         seen = rsp_valid[i];
         if (!seen) step();
      end
      if (!seen) timeout($sformatf("rsp_valid[%0d]", i));
   endtask

   task automatic read_word(input int i, input logic [31:0] pc, input logic [31:0] exp,
                            input bit exp_err, input string name);
      rsp_ready[i] = 1;
      send_req(i, pc);
      wait_valid(i);
      check(name, rsp_instr[i], exp);
`ifdef IFU_IMEM_ERR_EN
      check({name, "_err"}, 32'(rsp_err[i]), 32'(exp_err));
`else
      if (exp_err) check({name, "_fill"}, rsp_instr[i], FILL);
`endif
      step();
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) begin
         mmem[0][k] = '0;
         mmem[1][k] = '0;
      end
      rst = 0; req_valid = '0; rsp_ready = '0; req_pc = '0;
      wr_en = 0; wr_addr = '0; wr_data = '0;
      repeat (3) step();

      // Reset state
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_valid[%0d]", i), 32'(rsp_valid[i]), 32'd0);
         check($sformatf("reset_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
         check($sformatf("reset_instr[%0d]", i), rsp_instr[i], 32'd0);
      end
      rst = 1;

      // Preload, including two writes that must be dropped
      write_word(32'h8000_0000, 32'h0010_0093);
      write_word(32'h8000_0004, 32'h0020_0113);
      write_word(32'h8000_0008, 32'h1111_1111);
      write_word(32'h8000_0FFC, 32'hAAAA_5555);
      write_word(32'h8000_0006, 32'h5555_5555);
      write_word(32'h8000_1000, 32'h6666_6666);

      // LATENCY=1 single read: valid one cycle after the handshake
      rsp_ready[0] = 1;
      send_req(0, 32'h8000_0000);
      check("t1_valid", 32'(rsp_valid[0]), 32'd1);
      check("t1_instr", rsp_instr[0], 32'h0010_0093);
      step();

      // LATENCY=1 streaming at one word per cycle
      req_valid[0] = 1; req_pc[0] = 32'h8000_0000; step();
      req_pc[0] = 32'h8000_0004; step();
      req_pc[0] = 32'h8000_0FFC; step();
      req_valid[0] = 0;
      repeat (2) step();

      // LATENCY=3 back-to-back: responses at N+3 and N+6
      rsp_ready[1] = 1; req_valid[1] = 1; req_pc[1] = 32'h8000_0000;
      #1 check("t2_ready_idle", 32'(req_ready[1]), 32'd1);
      step();
      req_pc[1] = 32'h8000_0004;
      #1 check("t2_ready_wait1", 32'(req_ready[1]), 32'd0);
      step();
      #1 check("t2_ready_wait2", 32'(req_ready[1]), 32'd0);
      step();
      #1 check("t2_valid_n3", 32'(rsp_valid[1]), 32'd1);
      check("t2_instr_n3", rsp_instr[1], 32'h0010_0093);
      check("t2_ready_n3", 32'(req_ready[1]), 32'd1);
      step();
      req_valid[1] = 0;
      #1 check("t2_valid_n4", 32'(rsp_valid[1]), 32'd0);
      repeat (2) step();
      #1 check("t2_valid_n6", 32'(rsp_valid[1]), 32'd1);
      check("t2_instr_n6", rsp_instr[1], 32'h0020_0113);
      step();

      // Stalled response: held stable, no re-read after a later write
      rsp_ready[1] = 0;
      send_req(1, 32'h8000_0008);
      wait_valid(1);
      write_word(32'h8000_0008, 32'h2222_2222);
      repeat (3) step();
      check("t3_valid_hold", 32'(rsp_valid[1]), 32'd1);
      check("t3_ready_hold", 32'(req_ready[1]), 32'd0);
      check("t3_instr_hold", rsp_instr[1], 32'h1111_1111);
      rsp_ready[1] = 1;
      step();
      #1 check("t3_released", 32'(rsp_valid[1]), 32'd0);

      // Faulting and boundary addresses; the dropped misaligned write left
      // word 1 intact
      read_word(0, 32'h8000_0002, FILL, 1, "t4_misaligned");
      read_word(0, 32'h7FFF_FFFC, FILL, 1, "t4_below_base");
      read_word(0, 32'h8000_1000, FILL, 1, "t4_past_end");
      read_word(0, 32'hFFFF_FFFC, FILL, 1, "t4_top");
      read_word(0, 32'h8000_0FFC, 32'hAAAA_5555, 0, "t4_last_word");
      read_word(1, 32'h8000_0004, 32'h0020_0113, 0, "t4_drop_misaligned_wr");

      // Write on the edge that enters RESP is not visible (LATENCY=1)
      rsp_ready[0] = 1;
      req_valid[0] = 1; req_pc[0] = 32'h8000_0008;
      wr_en = 1; wr_addr = 32'h8000_0008; wr_data = 32'hDEAD_BEEF;
      step();
      req_valid[0] = 0; wr_en = 0;
      check("t5_old_word", rsp_instr[0], 32'h2222_2222);
      step();
      read_word(0, 32'h8000_0008, 32'hDEAD_BEEF, 0, "t5_reread");

      // LATENCY=3: write on the RESP-entry edge is hidden, an earlier one
      // is visible
      rsp_ready[1] = 1;
      send_req(1, 32'h8000_0000);
      step();
      write_word(32'h8000_0000, 32'h0123_4567);
      wait_valid(1);
      check("t5_l3_old", rsp_instr[1], 32'h0010_0093);
      step();
      send_req(1, 32'h8000_0FFC);
      write_word(32'h8000_0FFC, 32'h0BAD_F00D);
      wait_valid(1);
      check("t5_l3_early_wr", rsp_instr[1], 32'h0BAD_F00D);
      step();
      read_word(1, 32'h8000_0000, 32'h0123_4567, 0, "t5_l3_reread");

      // Reset during WAIT discards the request; a write under reset is ignored
      send_req(1, 32'h8000_0004);
      rst = 0; wr_en = 1; wr_addr = 32'h8000_0004; wr_data = 32'hBAD0_BAD0;
      step();
      rst = 1; wr_en = 0;
      check("t6_valid_after_rst", 32'(rsp_valid[1]), 32'd0);
      check("t6_ready_after_rst", 32'(req_ready[1]), 32'd1);
      repeat (4) step();
      check("t6_no_response", 32'(rsp_valid[1]), 32'd0);
      read_word(1, 32'h8000_0004, 32'h0020_0113, 0, "t6_ram_kept");

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
